// File: rtl/temporizador_pkg.sv
// -----------------------------------------------------------------------------
// temporizador_pkg
// Shared types and constants for the MM:SS countdown timer.
//   state_t     : timer FSM states (PAUSED only reachable with TEMPORIZADOR_PAUSE_EN)
//   SEC_PER_MIN : seconds per minute used by the BCD converter
//   BCD_W       : width of one BCD digit
// -----------------------------------------------------------------------------
package temporizador_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DONE   = 2'd2,
        PAUSED = 2'd3
    } state_t;

    localparam int unsigned SEC_PER_MIN = 60;
    localparam int unsigned BCD_W       = 4;

endpackage

// File: rtl/temporizador_mmss_secs_to_mmss_bcd.sv
// -----------------------------------------------------------------------------
// secs_to_mmss_bcd
// Combinational converter from seconds (0..255) to a 4-digit BCD MM:SS word.
// Ports:
//   secs_i : 8-bit seconds value
//   bcd_o  : {min_tens, min_units, sec_tens, sec_units}, 4 bits each
// Minutes never exceed 4 for an 8-bit input, so min_tens is always 0.
// -----------------------------------------------------------------------------
module secs_to_mmss_bcd
    import temporizador_pkg::*;
(
    input  logic [7:0]         secs_i,
    output logic [4*BCD_W-1:0] bcd_o
);

    logic [7:0]       sec_rem;
    logic [BCD_W-1:0] min_u;
    logic [BCD_W-1:0] sec_t;

    always_comb begin
        sec_rem = secs_i;
        min_u   = '0;
        sec_t   = '0;
        // 255 / 60 = 4, so four conditional subtractions cover the range
        for (int unsigned i = 0; i < 4; i++) begin
            if (sec_rem >= 8'(SEC_PER_MIN)) begin
                sec_rem = sec_rem - 8'(SEC_PER_MIN);
                min_u   = min_u + BCD_W'(1);
            end
        end
        // remainder is 0..59, so at most five subtractions of ten
        for (int unsigned i = 0; i < 5; i++) begin
            if (sec_rem >= 8'd10) begin
                sec_rem = sec_rem - 8'd10;
                sec_t   = sec_t + BCD_W'(1);
            end
        end
        bcd_o = {BCD_W'(0), min_u, sec_t, sec_rem[BCD_W-1:0]};
    end

endmodule

// File: rtl/temporizador_mmss.sv
// -----------------------------------------------------------------------------
// temporizador_mmss
// Countdown timer of `limite` seconds with a registered BCD MM:SS display word.
// Ports:
//   clk    : system clock, all state on rising edge
//   reset  : synchronous active-high reset
//   init   : level run request (1 = run, 0 = idle)
//   limite : interval in seconds, latched when leaving IDLE
//   numero : remaining time as BCD MM:SS, one cycle behind the counter
// Optional build macro TEMPORIZADOR_PAUSE_EN: dropping init in RUN pauses
// instead of aborting; only reset returns the timer to IDLE.
// -----------------------------------------------------------------------------
module temporizador_mmss
    import temporizador_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter int unsigned CNT_W         = 26
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic [7:0]  limite,
    output logic [15:0] numero
);

    localparam logic [CNT_W-1:0] PRESC_TC = CNT_W'(TICKS_PER_SEC - 1);

    state_t           state_q, state_d;
    logic [7:0]       rem_q, rem_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic [15:0]      numero_q;
    logic [15:0]      bcd_w;

    secs_to_mmss_bcd u_conv (
        .secs_i (rem_q),
        .bcd_o  (bcd_w)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        presc_d = presc_q;
        case (state_q)
            IDLE: begin
                rem_d   = limite;
                presc_d = '0;
                if (init) begin
                    if (limite != 8'd0) state_d = RUN;
                    else                state_d = DONE;
                end
            end
            RUN: begin
                if (!init) begin
`ifdef TEMPORIZADOR_PAUSE_EN
                    state_d = PAUSED;
`else
                    state_d = IDLE;
                    rem_d   = limite;
                    presc_d = '0;
`endif
                end else if (presc_q == PRESC_TC) begin
                    presc_d = '0;
                    if (rem_q != 8'd0) rem_d = rem_q - 8'd1;
                    if (rem_q <= 8'd1) state_d = DONE;
                end else begin
                    presc_d = presc_q + CNT_W'(1);
                end
            end
            DONE: begin
                rem_d   = '0;
                presc_d = '0;
                if (!init) state_d = IDLE;
            end
            PAUSED: begin
`ifdef TEMPORIZADOR_PAUSE_EN
                // counter and prescaler frozen; resume keeps the partial second
                if (init) state_d = RUN;
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            presc_q  <= '0;
            numero_q <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            presc_q  <= presc_d;
            numero_q <= bcd_w;
        end
    end

    assign numero = numero_q;

endmodule

// File: tb/tb_temporizador_mmss.sv
module tb_temporizador_mmss;

    logic        clk = 1'b0;
    logic        reset;
    logic        init;
    logic [7:0]  limite;
    logic [15:0] numero;

    int checks = 0;
    int errors = 0;

    temporizador_mmss #(
        .TICKS_PER_SEC (4),
        .CNT_W         (3)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .init   (init),
        .limite (limite),
        .numero (numero)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] exp);
        checks++;
        assert (numero === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, numero, exp);
        end
    endtask

    task automatic do_reset(input logic [7:0] lim);
        init   = 1'b0;
        limite = lim;
        reset  = 1'b1;
        step(1);
        reset  = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        init   = 1'b0;
        limite = 8'd70;

        // reset state and idle preview
        step(1);
        chk("reset_numero", 16'h0000);
        reset = 1'b0;
        step(1);
        chk("reset_rel_1", 16'h0000);
        step(1);
        chk("idle_preview_70", 16'h0110);

        // countdown from 70; limite change during run is ignored
        init = 1'b1;
        step(1);                      // RUN entry edge
        limite = 8'd200;
        step(4);
        chk("cd_before_first", 16'h0110);
        step(1);
        chk("cd_first_dec", 16'h0109);
        step(35);
        chk("cd_61", 16'h0101);
        step(1);
        chk("cd_60", 16'h0100);
        step(4);
        chk("cd_59", 16'h0059);

        // init drop after 6 run cycles
        do_reset(8'd70);
        step(2);
        init = 1'b1;
        step(1);                      // RUN entry
        step(6);
        chk("drop_pre", 16'h0109);
        init = 1'b0;
`ifdef TEMPORIZADOR_PAUSE_EN
        step(6);
        chk("pause_frozen", 16'h0109);
        init = 1'b1;
        step(3);
        chk("pause_resume_pre", 16'h0109);
        step(1);
        chk("pause_resume_dec", 16'h0108);
`else
        step(2);
        chk("abort_idle", 16'h0110);
        step(3);
        chk("abort_idle_hold", 16'h0110);
`endif

        // completion with limite=3
        do_reset(8'd3);
        step(2);
        chk("cmp_preview", 16'h0003);
        init = 1'b1;
        step(1);
        step(4);
        chk("cmp_3", 16'h0003);
        step(1);
        chk("cmp_2", 16'h0002);
        step(4);
        chk("cmp_1", 16'h0001);
        step(4);
        chk("cmp_0", 16'h0000);
        step(10);
        chk("cmp_done_hold", 16'h0000);
        init = 1'b0;
        step(3);
        chk("cmp_back_idle", 16'h0003);

        // limite=255 preview
        do_reset(8'd255);
        step(2);
        chk("idle_255", 16'h0415);

        // limite=0 goes straight to DONE and stays there
        do_reset(8'd0);
        step(2);
        chk("zero_idle", 16'h0000);
        init = 1'b1;
        step(1);
        limite = 8'd9;
        step(3);
        chk("zero_done", 16'h0000);

        // limite=60 minute boundary
        do_reset(8'd60);
        step(2);
        chk("b60_preview", 16'h0100);
        init = 1'b1;
        step(1);
        step(5);
        chk("b60_59", 16'h0059);

        // reset mid-run, then restart with prescaler from 0
        do_reset(8'd70);
        step(2);
        init = 1'b1;
        step(1);
        step(10);
        chk("mid_pre_reset", 16'h0108);
        reset = 1'b1;
        step(1);
        chk("mid_reset", 16'h0000);
        reset = 1'b0;
        step(1);                      // IDLE->RUN entry, rem loads 70
        chk("mid_restart_0", 16'h0000);
        step(4);
        chk("mid_restart_70", 16'h0110);
        step(1);
        chk("mid_restart_69", 16'h0109);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
